// File: rtl/alu_ctrl_pkg.sv
// Shared encodings for the ALU control sequencer: ALUOp/funct fields, operation codes,
// FSM state type and counter sizing.
package alu_ctrl_pkg;

    // ALUOp encodings from the main control unit
    localparam logic [3:0] AluopRtype = 4'b1111;
    localparam logic [3:0] AluopAddi  = 4'b1000;
    localparam logic [3:0] AluopOri   = 4'b1010;
    localparam logic [3:0] AluopAndi  = 4'b1100;
    localparam logic [3:0] AluopLui   = 4'b0010;
    localparam logic [3:0] AluopBr0   = 4'b0100;
    localparam logic [3:0] AluopBr1   = 4'b0111;
    localparam logic [3:0] AluopAdd0  = 4'b0110;
    localparam logic [3:0] AluopAdd1  = 4'b1110;

    // R-type funct encodings
    localparam logic [5:0] FnAnd  = 6'b100100;
    localparam logic [5:0] FnOr   = 6'b100101;
    localparam logic [5:0] FnNor  = 6'b100111;
    localparam logic [5:0] FnAdd  = 6'b100000;
    localparam logic [5:0] FnSub  = 6'b100010;
    localparam logic [5:0] FnSll  = 6'b000000;
    localparam logic [5:0] FnSrl  = 6'b000010;
    localparam logic [5:0] FnJr   = 6'b001000;
    localparam logic [5:0] FnSlt  = 6'b101010;
    localparam logic [5:0] FnXor  = 6'b100110;
    localparam logic [5:0] FnMult = 6'b011000;

    // ALU operation codes
    localparam logic [3:0] OpcAnd     = 4'b0000;
    localparam logic [3:0] OpcOr      = 4'b0001;
    localparam logic [3:0] OpcNor     = 4'b0010;
    localparam logic [3:0] OpcAdd     = 4'b0011;
    localparam logic [3:0] OpcSub     = 4'b0100;
    localparam logic [3:0] OpcSll     = 4'b0101;
    localparam logic [3:0] OpcSrl     = 4'b0110;
    localparam logic [3:0] OpcLui     = 4'b0111;
    localparam logic [3:0] OpcBrsub   = 4'b1000;
    localparam logic [3:0] OpcJr      = 4'b1001;
    localparam logic [3:0] OpcIllegal = 4'b1010;
    localparam logic [3:0] OpcMult    = 4'b1011;
    localparam logic [3:0] OpcSlt     = 4'b1100;
    localparam logic [3:0] OpcXor     = 4'b1101;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StMulti
    } state_e;

    function automatic int unsigned cnt_width(input int unsigned lat);
        return (lat <= 2) ? 1 : $clog2(lat);
    endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational {ALUOp, funct} to ALU operation-code table.
// funct 011000 decodes to MULT only when ALU_MULT_EN is defined.
module alu_ctrl_decode
    import alu_ctrl_pkg::*;
(
    input  logic [3:0] alu_op_i,
    input  logic [5:0] alu_funct_i,
    output logic [3:0] operation_o
);

    always_comb begin
        operation_o = OpcIllegal;
        unique case (alu_op_i)
            AluopRtype: begin
                case (alu_funct_i)
                    FnAnd:   operation_o = OpcAnd;
                    FnOr:    operation_o = OpcOr;
                    FnNor:   operation_o = OpcNor;
                    FnAdd:   operation_o = OpcAdd;
                    FnSub:   operation_o = OpcSub;
                    FnSll:   operation_o = OpcSll;
                    FnSrl:   operation_o = OpcSrl;
                    FnJr:    operation_o = OpcJr;
                    FnSlt:   operation_o = OpcSlt;
                    FnXor:   operation_o = OpcXor;
`ifdef ALU_MULT_EN
                    FnMult:  operation_o = OpcMult;
`endif
                    default: operation_o = OpcIllegal;
                endcase
            end
            AluopAddi, AluopAdd0, AluopAdd1: operation_o = OpcAdd;
            AluopOri:                        operation_o = OpcOr;
            AluopAndi:                       operation_o = OpcAnd;
            AluopLui:                        operation_o = OpcLui;
            AluopBr0, AluopBr1:              operation_o = OpcBrsub;
            default:                         operation_o = OpcIllegal;
        endcase
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// Registered, handshaked ALU control decoder with optional multi-cycle MULT sequencing.
// Define ALU_MULT_EN to build the MULTI state and latency counter.
module alu_op_sequencer
    import alu_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = 4,
    parameter int unsigned OPER_W   = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              dec_valid_i,
    output logic              dec_ready_o,
    input  logic [3:0]        alu_op_i,
    input  logic [5:0]        alu_funct_i,
    output logic [OPER_W-1:0] alu_operation_o,
    output logic              op_valid_o,
    output logic              illegal_o,
    output logic              jr_o,
    output logic              busy_o
);

    if (OPER_W < 4) begin : g_oper_w_check
        $error("OPER_W must be at least 4");
    end

    state_e     state_q;
    logic [3:0] op_q;
    logic       valid_q;
    logic [3:0] dec_code;
    logic       xfer;

    alu_ctrl_decode u_decode (
        .alu_op_i    (alu_op_i),
        .alu_funct_i (alu_funct_i),
        .operation_o (dec_code)
    );

    assign xfer = dec_valid_i && dec_ready_o;

`ifdef ALU_MULT_EN
    if (MULT_LAT < 2 || MULT_LAT > 16) begin : g_lat_check
        $error("MULT_LAT must be in 2..16");
    end

    localparam int unsigned CntW = cnt_width(MULT_LAT);

    logic [CntW-1:0] cnt_q;
    logic            busy_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpcIllegal;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                StIdle, StActive: begin
                    if (xfer) begin
                        op_q <= dec_code;
                        if (dec_code == OpcMult) begin
                            state_q <= StMulti;
                            valid_q <= 1'b0;
                            busy_q  <= 1'b1;
                            cnt_q   <= CntW'(MULT_LAT - 2);
                        end else begin
                            state_q <= StActive;
                            valid_q <= 1'b1;
                        end
                    end else begin
                        state_q <= StIdle;
                        valid_q <= 1'b0;
                    end
                end
                StMulti: begin
                    if (cnt_q == '0) begin
                        state_q <= StActive;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign dec_ready_o = ~busy_q;
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            op_q    <= OpcIllegal;
            valid_q <= 1'b0;
        end else if (xfer) begin
            state_q <= StActive;
            op_q    <= dec_code;
            valid_q <= 1'b1;
        end else begin
            state_q <= StIdle;
            valid_q <= 1'b0;
        end
    end

    assign busy_o      = 1'b0;
    assign dec_ready_o = 1'b1;
`endif

    assign alu_operation_o = OPER_W'(op_q);
    assign op_valid_o      = valid_q;
    assign illegal_o       = valid_q && (op_q == OpcIllegal);
    assign jr_o            = valid_q && (op_q == OpcJr);

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed, table-driven bench for alu_op_sequencer; MULT sequences run when ALU_MULT_EN is set.
module tb_alu_op_sequencer;

    localparam int unsigned Lat  = 4;
    localparam int unsigned OperW = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             dec_valid_i;
    logic             dec_ready_o;
    logic [3:0]       alu_op_i;
    logic [5:0]       alu_funct_i;
    logic [OperW-1:0] alu_operation_o;
    logic             op_valid_o;
    logic             illegal_o;
    logic             jr_o;
    logic             busy_o;

    int checks = 0;
    int errors = 0;
    logic busy_seen = 1'b0;

    alu_op_sequencer #(
        .MULT_LAT (Lat),
        .OPER_W   (OperW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .dec_valid_i     (dec_valid_i),
        .dec_ready_o     (dec_ready_o),
        .alu_op_i        (alu_op_i),
        .alu_funct_i     (alu_funct_i),
        .alu_operation_o (alu_operation_o),
        .op_valid_o      (op_valid_o),
        .illegal_o       (illegal_o),
        .jr_o            (jr_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (busy_o === 1'b1) busy_seen <= 1'b1;

    typedef struct {
        logic [3:0] op;
        logic [5:0] fn;
        logic [3:0] code;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Checks all outputs; call #1 after a rising edge.
    task automatic check_all(input string name, input logic [3:0] code, input logic valid,
                             input logic busy, input logic ready);
        check({name, ".code"}, 32'(alu_operation_o), 32'(code));
        check({name, ".valid"}, 32'(op_valid_o), 32'(valid));
        check({name, ".illegal"}, 32'(illegal_o), 32'(valid && code == 4'b1010));
        check({name, ".jr"}, 32'(jr_o), 32'(valid && code == 4'b1001));
        check({name, ".busy"}, 32'(busy_o), 32'(busy));
        check({name, ".ready"}, 32'(dec_ready_o), 32'(ready));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [3:0] op, input logic [5:0] fn);
        @(negedge clk);
        dec_valid_i = v;
        alu_op_i    = op;
        alu_funct_i = fn;
    endtask

    task automatic add_vec(input logic [3:0] op, input logic [5:0] fn, input logic [3:0] code);
        vec_t v;
        v.op = op;
        v.fn = fn;
        v.code = code;
        vecs.push_back(v);
    endtask

    initial begin
        reset       = 1'b1;
        dec_valid_i = 1'b0;
        alu_op_i    = 4'b0;
        alu_funct_i = 6'b0;

        add_vec(4'b1010, 6'b000000, 4'b0001);
        add_vec(4'b0100, 6'b100000, 4'b1000);
        add_vec(4'b1111, 6'b101010, 4'b1100);
        add_vec(4'b1111, 6'b100100, 4'b0000);
        add_vec(4'b1111, 6'b100101, 4'b0001);
        add_vec(4'b1111, 6'b100111, 4'b0010);
        add_vec(4'b1111, 6'b100010, 4'b0100);
        add_vec(4'b1111, 6'b000000, 4'b0101);
        add_vec(4'b1111, 6'b000010, 4'b0110);
        add_vec(4'b1111, 6'b001000, 4'b1001);
        add_vec(4'b1111, 6'b100110, 4'b1101);
        add_vec(4'b1111, 6'b111111, 4'b1010);
        add_vec(4'b0001, 6'b100000, 4'b1010);
        add_vec(4'b1111, 6'b000001, 4'b1010);
        add_vec(4'b1000, 6'b111111, 4'b0011);
        add_vec(4'b1100, 6'b100101, 4'b0000);
        add_vec(4'b0010, 6'b000000, 4'b0111);
        add_vec(4'b0111, 6'b101010, 4'b1000);
        add_vec(4'b0110, 6'b100100, 4'b0011);
        add_vec(4'b1110, 6'b011000, 4'b0011);
        add_vec(4'b0000, 6'b100000, 4'b1010);
        add_vec(4'b1001, 6'b100000, 4'b1010);
`ifndef ALU_MULT_EN
        add_vec(4'b1111, 6'b011000, 4'b1010);
`endif

        step();
        step();
        check_all("reset", 4'b1010, 1'b0, 1'b0, 1'b1);

        // Reset wins over a simultaneous transfer
        drive(1'b1, 4'b1111, 6'b100000);
        step();
        check_all("rst_prio", 4'b1010, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        dec_valid_i = 1'b0;
        step();
        check_all("idle", 4'b1010, 1'b0, 1'b0, 1'b1);

        // Single ADD, then valid drops while the code holds
        drive(1'b1, 4'b1111, 6'b100000);
        step();
        check_all("add", 4'b0011, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 6'b000000);
        step();
        check_all("add_hold", 4'b0011, 1'b0, 1'b0, 1'b1);

        // Back-to-back table vectors give continuous op_valid_o
        foreach (vecs[i]) begin
            drive(1'b1, vecs[i].op, vecs[i].fn);
            step();
            check_all($sformatf("vec%0d", i), vecs[i].code, 1'b1, 1'b0, 1'b1);
        end
        drive(1'b0, 4'b0000, 6'b000000);
        step();
        check_all("tbl_end", vecs[vecs.size()-1].code, 1'b0, 1'b0, 1'b1);

`ifdef ALU_MULT_EN
        // MULT with next op held during busy
        drive(1'b1, 4'b1111, 6'b011000);
        step();
        check_all("mult_b0", 4'b1011, 1'b0, 1'b1, 1'b0);
        drive(1'b1, 4'b1111, 6'b100010);
        for (int c = 1; c < Lat - 1; c++) begin
            step();
            check_all($sformatf("mult_b%0d", c), 4'b1011, 1'b0, 1'b1, 1'b0);
        end
        step();
        check_all("mult_res", 4'b1011, 1'b1, 1'b0, 1'b1);
        step();
        check_all("mult_next", 4'b0100, 1'b1, 1'b0, 1'b1);
        drive(1'b0, 4'b0000, 6'b000000);
        step();
        check_all("mult_idle", 4'b0100, 1'b0, 1'b0, 1'b1);

        // Reset in the second MULTI cycle aborts the op
        drive(1'b1, 4'b1111, 6'b011000);
        step();
        drive(1'b0, 4'b0000, 6'b000000);
        step();
        check_all("abort_b1", 4'b1011, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        step();
        check_all("abort_rst", 4'b1010, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        reset = 1'b0;
        for (int c = 0; c < Lat; c++) begin
            step();
            check_all($sformatf("abort_quiet%0d", c), 4'b1010, 1'b0, 1'b0, 1'b1);
        end
`else
        check("busy_never", 32'(busy_seen), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_op_sequencer.md
# alu_op_sequencer

Registered, handshaked successor to the combinational ALU control decoder. Each cycle it accepts one {ALUOp, funct} pair from the main control/instruction fields and decodes it into an ALU operation code. It presents that code from a pipeline register. For multi-cycle operations (MULT), it holds the issue stage busy for a parametrised latency. It sits between the control unit and the ALU, and its `dec_ready_o` feeds the pipeline stall logic.

## Interface
- `MULT_LAT`, 4: cycles from MULT acceptance to result-valid; legal range 2..16. Out-of-range values are an elaboration error.
- `OPER_W`, 4: width of `alu_operation_o`; must be ≥4; codes are zero-extended.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `dec_valid_i` in 1: ALUOp/funct present and valid this cycle.
- `dec_ready_o` out 1: sequencer accepts this cycle. Transfer happens when `dec_valid_i && dec_ready_o`.
- `alu_op_i` in 4: ALUOp from the control unit.
- `alu_funct_i` in 6: instruction funct field.
- `alu_operation_o` out OPER_W: registered operation code.
- `op_valid_o` out 1: `alu_operation_o` is valid this cycle (one cycle per accepted op).
- `illegal_o` out 1: high with `op_valid_o` when the code is ILLEGAL.
- `jr_o` out 1: high with `op_valid_o` when the code is JR.
- `busy_o` out 1: high while in MULTI.

## Operation
- Operation codes:
  - AND 0000, OR 0001, NOR 0010, ADD 0011, SUB 0100
  - SLL 0101, SRL 0110, LUI 0111, BRSUB 1000, JR 1001
  - ILLEGAL 1010, MULT 1011, SLT 1100, XOR 1101
- R-type decode (ALUOp 1111), by funct:
  - 100100 AND, 100101 OR, 100111 NOR, 100000 ADD, 100010 SUB
  - 000000 SLL, 000010 SRL, 001000 JR, 101010 SLT, 100110 XOR
  - 011000 MULT (macro-gated)
  - any other funct → ILLEGAL
- I-type decode, by ALUOp only (funct ignored):
  - 1000 ADD, 1010 OR, 1100 AND, 0010 LUI
  - 0100 and 0111 BRSUB; 0110 and 1110 ADD
  - any other ALUOp → ILLEGAL
- FSM states:
  - IDLE: `dec_ready_o`=1, `op_valid_o`=0.
  - ACTIVE: `op_valid_o`=1, `dec_ready_o`=1.
  - MULTI: `busy_o`=1, `dec_ready_o`=0, `op_valid_o`=0; a down-counter is loaded with MULT_LAT-2 on entry.
- Transitions:
  - IDLE/ACTIVE + transfer of a single-cycle op → ACTIVE; the new code is registered.
  - IDLE/ACTIVE + transfer of MULT → MULTI; the code register is loaded with MULT.
  - ACTIVE with no transfer → IDLE.
  - MULTI with counter==0 → ACTIVE; the counter otherwise decrements.
- ILLEGAL and JR are single-cycle ops. `illegal_o` and `jr_o` are decoded from the registered code and gated by `op_valid_o`.
- `alu_operation_o` holds its last value while `op_valid_o`=0.

## Timing
- Reset values:
  - state IDLE, counter 0
  - `alu_operation_o`=ILLEGAL (1010)
  - `op_valid_o`=0, `illegal_o`=0, `jr_o`=0, `busy_o`=0
  - `dec_ready_o`=1 from the first cycle after reset
- Single-cycle latency: transfer at edge N gives `op_valid_o` high for the cycle after edge N. Back-to-back transfers give continuous `op_valid_o`.
- MULT latency: transfer at edge N gives `busy_o` high for MULT_LAT-1 cycles, then `op_valid_o` high in cycle MULT_LAT after edge N.
- MULT_LAT=2: MULTI lasts exactly one cycle.
- `dec_valid_i` while `dec_ready_o`=0: ignored. The source must hold its inputs until the transfer.
- Reset asserted mid-MULTI: abort at the next edge, go to IDLE, no `op_valid_o` for the aborted op.
- Reset has priority over a simultaneous transfer.
- Inputs are don't-care when `dec_valid_i`=0.

## Configuration
- `ALU_MULT_EN` defined:
  - funct 011000 decodes to MULT; the MULTI state and counter are built.
- `ALU_MULT_EN` undefined:
  - funct 011000 → ILLEGAL.
  - MULTI state and counter are not built.
  - `busy_o` is tied 0 and `dec_ready_o` is tied 1.
  - `MULT_LAT` is ignored, including its range check.

## Structure
- Package `alu_ctrl_pkg`:
  - ALUOp encodings, funct encodings, operation-code constants
  - FSM state enum
  - counter width function (clog2 of MULT_LAT)
- Sub-module `alu_ctrl_decode`: a purely combinational {ALUOp, funct} → operation-code table, instantiated once before the pipeline register.

## Test plan
- Reset, then ALUOp 1111 / funct 100000 with valid for one cycle → next cycle `alu_operation_o`=0011, `op_valid_o`=1; the following cycle `op_valid_o`=0.
- Back-to-back ALUOp 1010, then 0100, then 1111/101010 → `op_valid_o` high for 3 consecutive cycles with codes 0001, 1000, 1100.
- ALUOp 1111 / funct 111111, then ALUOp 0001 → two `op_valid_o` cycles, code 1010 each time, `illegal_o`=1 both times. Also ALUOp 1111 / funct 001000 → code 1001, `jr_o`=1.
- `ALU_MULT_EN`, MULT_LAT=4, funct 011000 → `busy_o` high 3 cycles with `dec_ready_o`=0 and the held next input ignored, then code 1011 with `op_valid_o`=1 and `dec_ready_o`=1.
- `ALU_MULT_EN`, reset asserted in the 2nd MULTI cycle → next cycle IDLE, `busy_o`=0, `op_valid_o`=0, `alu_operation_o`=1010.
- `ALU_MULT_EN` undefined, funct 011000 → single cycle, code 1010, `illegal_o`=1, `busy_o` never high.
